// File: rtl/simon_sequence_player.sv
// Simon Says colour sequence store and player: appends LFSR colours on request and
// replays the stored sequence as timed ON/OFF LED flashes.
module simon_sequence_player #(
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned ON_CYCLES  = 12_500_000,
  parameter int unsigned OFF_CYCLES = 6_250_000,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5,
  localparam int unsigned LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          extend,
  input  logic          start,
  output logic [1:0]    led_in,
  output logic          led_on,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] length,
  output logic          full
);

  localparam int unsigned IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned PMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned CW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [CW-1:0] ON_LOAD   = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LOAD  = CW'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [LW-1:0] length_q, length_d;
  logic          full_q, full_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    led_q, led_d;
  logic          done_q, done_d;
  logic [1:0]    mem_q [MAX_LEN];

  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] idx_nxt;
  logic [LW-1:0] last_len;

  // Taps x^8+x^6+x^5+x^4+1 map to bits 7,5,4,3 of a left-shifting register.
  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign wr_idx   = length_q[IW-1:0];
  assign idx_nxt  = idx_q + 1'b1;
  assign last_len = length_q - 1'b1;

  always_comb begin
    state_d  = state_q;
    length_d = length_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clear) begin
          length_d = '0;
        end else if (extend) begin
          if (!full_q) begin
            wr_en    = 1'b1;
            length_d = length_q + 1'b1;
          end
        end else if (start) begin
          if (length_q == '0) begin
            done_d = 1'b1;
          end else begin
            idx_d   = '0;
            led_d   = mem_q[0];
            cnt_d   = ON_LOAD;
            state_d = S_ON;
          end
        end
      end
      S_ON: begin
        if (cnt_q == '0) begin
          cnt_d   = OFF_LOAD;
          state_d = S_OFF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_OFF: begin
        if (cnt_q == '0) begin
          if (LW'(idx_q) == last_len) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_nxt;
            led_d   = mem_q[idx_nxt];
            cnt_d   = ON_LOAD;
            state_d = S_ON;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    full_d = (length_d == MAX_LEN_L);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_SEED;
      length_q <= '0;
      full_q   <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      led_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      length_q <= length_d;
      full_q   <= full_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      done_q   <= done_d;
    end
  end

  // Sequence contents are deliberately left unreset; only length is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= lfsr_q[1:0];
    end
  end

  assign led_in = led_q;
  assign led_on = (state_q == S_ON);
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign length = length_q;
  assign full   = full_q;

endmodule

// File: tb/tb_simon_sequence_player.sv
// Self-checking bench for simon_sequence_player: directed scenarios followed by a
// randomized command stream compared against a formula-based playback model.
module tb_simon_sequence_player;

  localparam int unsigned MAXL = 4;
  localparam int unsigned ONC  = 3;
  localparam int unsigned OFFC = 2;
  localparam int unsigned P    = ONC + OFFC;

  logic       clk, rst, clear, extend, start;
  logic [1:0] led_in;
  logic       led_on, busy, done, full;
  logic [2:0] length;

  int unsigned checks = 0;
  int unsigned errors = 0;

  simon_sequence_player #(
    .MAX_LEN   (MAXL),
    .ON_CYCLES (ONC),
    .OFF_CYCLES(OFFC),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .extend(extend),
    .start (start),
    .led_in(led_in),
    .led_on(led_on),
    .busy  (busy),
    .done  (done),
    .length(length),
    .full  (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: feedback is the parity of the tapped bits (mask 0xB8).
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_colour(input logic [1:0] tgt);
    int n = 0;
    while (m_lfsr[1:0] != tgt && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) begin
      errors++;
      $display("FAIL lfsr_wait observed=timeout expected=colour %0d", tgt);
    end
  endtask

  logic [1:0] seq3 [3];
  logic [1:0] col [5];
  logic [1:0] mq [$];
  logic       play, mdone, nd, rc, re, rs;
  logic [1:0] last_led;
  int unsigned pc;

  initial begin
    seq3 = '{2'd1, 2'd2, 2'd3};
    rst = 1'b1; clear = 1'b0; extend = 1'b0; start = 1'b0;
    step(); step();
    chk("rst_led_in", led_in, 0);
    chk("rst_led_on", led_on, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_length", length, 0);
    chk("rst_full", full, 0);

    // start with an empty sequence
    rst = 1'b0; start = 1'b1; step(); start = 1'b0;
    chk("empty_done", done, 1);
    chk("empty_busy", busy, 0);
    step();
    chk("empty_done_end", done, 0);
    chk("empty_busy_end", busy, 0);

    // first append right after reset release picks seed bits 01
    rst = 1'b1; step(); step();
    rst = 1'b0; extend = 1'b1; step(); extend = 1'b0;
    chk("first_len", length, 1);
    wait_colour(2'd2); extend = 1'b1; step(); extend = 1'b0;
    wait_colour(2'd3); extend = 1'b1; step(); extend = 1'b0;
    chk("three_len", length, 3);
    chk("three_full", full, 0);

    // playback of 01,10,11
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 15; c++) begin
      chk("pb_busy", busy, 1);
      chk("pb_led_on", led_on, ((c % 5) < 3) ? 1 : 0);
      chk("pb_led_in", led_in, seq3[c / 5]);
      chk("pb_done", done, 0);
      step();
    end
    chk("pb_end_done", done, 1);
    chk("pb_end_busy", busy, 0);
    chk("pb_end_led_on", led_on, 0);
    chk("pb_end_led_in", led_in, 3);

    // restart in the done cycle, commands ignored while busy, then reset mid-ON
    start = 1'b1; step(); start = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_led_on", led_on, 1);
    chk("restart_done", done, 0);
    extend = 1'b1; step(); extend = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    chk("busy_len_hold", length, 3);
    chk("busy_still_on", led_on, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_led_on", led_on, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_length", length, 0);
    chk("midrst_done", done, 0);
    step();
    chk("midrst_no_done", done, 0);
    chk("midrst_idle", busy, 0);

    // priority
    extend = 1'b1; start = 1'b1; step(); extend = 1'b0; start = 1'b0;
    chk("ext_start_len", length, 1);
    chk("ext_start_busy", busy, 0);
    step();
    chk("ext_start_busy2", busy, 0);
    chk("ext_start_done", done, 0);
    clear = 1'b1; extend = 1'b1; step(); clear = 1'b0; extend = 1'b0;
    chk("clr_ext_len", length, 0);

    // capacity
    for (int i = 0; i < 5; i++) begin
      col[i] = m_lfsr[1:0];
      extend = 1'b1; step();
      chk("cap_len", length, (i < 4) ? i + 1 : 4);
      chk("cap_full", full, (i >= 3) ? 1 : 0);
    end
    extend = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if ((c % 5) == 0) chk("cap_led_in", led_in, col[c / 5]);
      step();
    end
    chk("cap_pb_done", done, 1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("cap_clr_len", length, 0);
    chk("cap_clr_full", full, 0);

    // randomized commands against the playback model
    rst = 1'b1; step(); rst = 1'b0;
    mq.delete(); play = 1'b0; mdone = 1'b0; last_led = 2'd0; pc = 0;
    for (int n = 0; n < 400; n++) begin
      if (play) begin
        chk("rnd_busy", busy, 1);
        chk("rnd_led_on", led_on, ((pc % P) < ONC) ? 1 : 0);
        chk("rnd_led_in", led_in, mq[pc / P]);
      end else begin
        chk("rnd_busy", busy, 0);
        chk("rnd_led_on", led_on, 0);
        chk("rnd_led_in", led_in, last_led);
      end
      chk("rnd_done", done, mdone);
      chk("rnd_length", length, mq.size());
      chk("rnd_full", full, (mq.size() == MAXL) ? 1 : 0);

      rc = ($urandom_range(15) == 0);
      re = ($urandom_range(2) == 0);
      rs = ($urandom_range(5) == 0);
      clear = rc; extend = re; start = rs;

      nd = 1'b0;
      if (play) begin
        pc++;
        if (pc == mq.size() * P) begin
          play = 1'b0;
          nd = 1'b1;
          last_led = mq[mq.size() - 1];
        end
      end else if (rc) begin
        mq.delete();
      end else if (re) begin
        if (mq.size() < MAXL) mq.push_back(m_lfsr[1:0]);
      end else if (rs) begin
        if (mq.size() == 0) nd = 1'b1;
        else begin
          play = 1'b1;
          pc = 0;
        end
      end
      mdone = nd;
      step();
    end
    clear = 1'b0; extend = 1'b0; start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simon_sequence_player.md
# simon_sequence_player

Generates, stores and replays the Simon Says colour sequence. New random colours are appended one per request from a free-running LFSR. On `start`, the stored sequence is played back as timed LED flashes. The outputs `led_in` and `led_on` sit directly upstream of the 2-to-4 one-hot LED decoder: `led_in` drives the decoder input, and `led_on` gates the decoder output.

## Interface
- `MAX_LEN`, default 16: sequence capacity in entries, ≥1.
- `ON_CYCLES`, default 12_500_000: cycles each colour is lit, ≥1.
- `OFF_CYCLES`, default 6_250_000: dark gap after each colour, ≥1.
- `LFSR_SEED`, default 8'hA5: LFSR reset value; must be non-zero.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clear`  in  1  empties the stored sequence.
- `extend`  in  1  appends one random colour.
- `start`  in  1  begins playback of the stored sequence.
- `led_in`  out  2  colour index of the current entry; feeds the decoder.
- `led_on`  out  1  high while a colour is being shown.
- `busy`  out  1  high during playback.
- `done`  out  1  one-cycle pulse when playback completes.
- `length`  out  $clog2(MAX_LEN+1)  number of stored entries.
- `full`  out  1  `length == MAX_LEN`.

## Operation
- **LFSR**
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, shifting every cycle including during playback.
  - The appended colour is `lfsr[1:0]`, sampled in the cycle `extend` is accepted.
- **Storage:** MAX_LEN×2-bit register array. Contents are not reset; only `length` is.
- **States:** IDLE, ON, OFF.
- **IDLE:** commands are sampled in priority order clear > extend > start. At most one command is acted on per cycle; lower-priority commands in the same cycle are dropped.
  - `clear`: `length` ← 0.
  - `extend`:
    - not full: `mem[length]` ← `lfsr[1:0]`, `length` ← `length`+1.
    - full: ignored.
  - `start`:
    - `length`==0: no playback, `done` pulses the next cycle, `busy` stays 0.
    - otherwise: index ← 0, state ← ON.
- **ON:**
  - `led_on`=1, `led_in`=`mem[index]`.
  - After ON_CYCLES cycles, go to OFF.
- **OFF:**
  - `led_on`=0; `led_in` holds the last value.
  - After OFF_CYCLES cycles: if index==`length`−1, go to IDLE and pulse `done`; else index+1 and go to ON.
- While `busy`, all of `clear`, `extend` and `start` are ignored, so `length` is constant during playback.
- The phase counter is `$clog2(max(ON_CYCLES,OFF_CYCLES))` bits wide and reloads on every state change. The index counter never wraps past `length`−1.

## Timing
- **Reset values:** state IDLE, `length`=0, `led_in`=0, `led_on`=0, `busy`=0, `done`=0, `full`=0, `lfsr`=LFSR_SEED.
- `rst` overrides everything. Asserted mid-playback, it forces the reset values at the next edge with no `done` pulse.
- **Start accepted at edge of cycle T (`length`=L>0):**
  - `busy`=1 and `led_on`=1 from cycle T+1.
  - Entry k is lit in cycles T+1+k·P … T+k·P+ON_CYCLES, where P=ON_CYCLES+OFF_CYCLES.
  - `busy` falls and `done`=1 in cycle T+1+L·P, for exactly one cycle.
- `extend` and `clear` take effect at the next edge; `length` and `full` are registered.
- A new `start` is accepted in the same cycle `done` is high.

## Test plan
- **Reset:** assert `rst` 2 cycles → all outputs 0, `lfsr`=8'hA5; hold `start` with `length`=0 → `done` pulses one cycle later, `busy` stays 0.
- **First append:** `extend` in the first cycle after reset release → `length`=1, `mem[0]`=2'b01 (`lfsr[1:0]` of 8'hA5). Further entries must match a bench LFSR model.
- **Playback** (ON=3, OFF=2, L=3, sequence 01,10,11):
  - `start` pulse → `busy` high 15 cycles.
  - `led_on` pattern 1,1,1,0,0 ×3; `led_in` 1,2,3 during the respective lit windows.
  - `done` in cycle 16 after `start`.
- **Capacity** (MAX_LEN=4): 5 `extend` pulses → `length`=4, `full`=1, 5th ignored; then `clear` → `length`=0, `full`=0.
- **Priority:**
  - `clear`+`extend` same cycle → `length`=0.
  - `extend`+`start` same cycle → `length`+1, no playback.
  - `extend`/`clear` during `busy` → `length` unchanged.
- **Reset mid-playback:** `rst` in an ON phase → next cycle `led_on`=0, `busy`=0, `length`=0, no `done` pulse.
